ex_mem_skid: RTL
================

EX_MEM_SKID -- requirements
Module: ex_mem_skid

Interface
REQ-001 Parameter DATA_W, 32, width of ALU result and store-data fields.
REQ-002 Parameter REG_W, 5, width of destination-register field.
REQ-003 Parameter WB_W, 2, width of write-back control field.
REQ-004 Parameter CNT_W, 16, width of stall counter.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  upstream (EX) entry present.
REQ-008 in_ready  output  1  stage can accept an entry this cycle.
REQ-009 flush  input  1  synchronous kill of all held entries.
REQ-010 wb  input  WB_W  write-back control.
REQ-011 m  input  2  memory control; bit1 = read, bit0 = write.
REQ-012 alu_in  input  DATA_W  ALU result / address.
REQ-013 store_in  input  DATA_W  store data.
REQ-014 rd_in  input  REG_W  destination register.
REQ-015 out_valid  output  1  output entry present.
REQ-016 out_ready  input  1  downstream (MEM) consumes entry this cycle.
REQ-017 wb_out, mem_read, mem_write, alu_out, store_out, rd_out  output  WB_W/1/1/DATA_W/DATA_W/REG_W  held entry fields.
REQ-018 m_conflict  output  1  sticky: an accepted entry had m = 2'b11.
REQ-019 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-020 Accept = in_valid & in_ready; consume = out_valid & out_ready; both evaluated each cycle.
REQ-021 Two slots SHALL exist: output slot (drives outputs) and skid slot; in_ready SHALL equal NOT skid-slot valid.
REQ-022 Output slot empty or consumed, skid empty: accepted entry SHALL load output slot; out_valid high the next cycle (latency 1).
REQ-023 Output slot full, not consumed, entry accepted: entry SHALL load skid slot; in_ready low the next cycle.
REQ-024 Skid full and output consumed: skid entry SHALL move to output slot and skid SHALL empty; no input accepted that cycle (in_ready=0).
REQ-025 Entries SHALL leave in acceptance order; none dropped or duplicated except by flush.
REQ-026 mem_read = m[1] & out_valid; mem_write = m[0] & ~m[1] & out_valid; wb_out = stored wb when out_valid, else 0.
REQ-027 Accepted m = 2'b11 SHALL be treated as read only and SHALL set m_conflict, which stays 1 until reset.
REQ-028 alu_out, store_out, rd_out SHALL hold last loaded value when out_valid=0 (not masked).
REQ-029 flush=1 SHALL clear both slot valids next cycle, accept nothing that cycle, and take precedence over accept and consume; data fields unchanged.
REQ-030 stall_cnt SHALL increment by 1 on each cycle with out_valid=1 and out_ready=0, saturate at 2^CNT_W-1, unaffected by flush.
REQ-031 Simultaneous accept and consume with skid empty SHALL sustain one entry per cycle with in_ready held 1.

Reset
REQ-032 rst_n low SHALL immediately clear both slot valids, all data fields, m_conflict and stall_cnt to 0.
REQ-033 During and after reset: out_valid=0, mem_read=0, mem_write=0, wb_out=0, in_ready=1.
REQ-034 Reset deasserted mid-transfer SHALL lose all in-flight entries; first accept possible on the first rising edge after deassertion.

Structure
REQ-035 Package ex_mem_pkg SHALL hold M_READ_BIT=1, M_WRITE_BIT=0 and the default DATA_W/REG_W/WB_W constants.
REQ-036 One sub-module pipe_slot (valid bit plus payload register with load/clear) SHALL be instantiated twice; counter and masking in ex_mem_skid.

Verification
REQ-037 Reset, then in_valid=1, m=2'b10, alu_in=0x100, rd_in=3, out_ready=1 -> next cycle out_valid=1, mem_read=1, alu_out=0x100, rd_out=3.
REQ-038 out_ready=0, push entries A, B -> A in output slot, B in skid, in_ready=0; out_ready=1 two cycles -> A then B, in_ready back to 1, stall_cnt equals stalled cycles.
REQ-039 Streaming 8 entries with out_ready=1 constantly -> 8 consecutive out_valid cycles, order preserved, in_ready never 0.
REQ-040 Both slots full, flush=1 with in_valid=1 -> next cycle out_valid=0, mem_read=mem_write=0, wb_out=0, in_ready=1; flushed input absent.
REQ-041 Accept m=2'b11 -> mem_read=1, mem_write=0, m_conflict=1 persisting until rst_n pulse.
REQ-042 CNT_W=4, out_ready=0 for 20 cycles with out_valid=1 -> stall_cnt=15; rst_n low mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared constants and helpers for the EX/MEM skid-buffered pipeline register.
package ex_mem_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int REG_W_DEFAULT  = 5;
    localparam int WB_W_DEFAULT   = 2;
    localparam int CNT_W_DEFAULT  = 16;

    localparam int M_READ_BIT  = 1;
    localparam int M_WRITE_BIT = 0;

    // A read+write request is downgraded to a plain read.
    function automatic logic [1:0] mem_ctrl(input logic [1:0] m, input logic valid);
        return {valid & m[M_READ_BIT], valid & m[M_WRITE_BIT] & ~m[M_READ_BIT]};
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: a valid flag plus a payload register; clear wins over load.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (i_clear) begin
                r_valid <= 1'b0;
            end else if (i_load) begin
                r_valid <= 1'b1;
                r_data  <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline register with a one-entry skid buffer so in_ready is a pure register output.
module ex_mem_skid
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int REG_W  = REG_W_DEFAULT,
    parameter int WB_W   = WB_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [WB_W-1:0]   wb,
    input  logic [1:0]        m,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] store_in,
    input  logic [REG_W-1:0]  rd_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   wb_out,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] store_out,
    output logic [REG_W-1:0]  rd_out,
    output logic              m_conflict,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int PAY_W = WB_W + 2 + 2 * DATA_W + REG_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             w_outValid, w_skidValid;
    logic             w_accept, w_consume;
    logic             w_outLoad, w_outClear, w_skidLoad, w_skidClear;
    logic [PAY_W-1:0] w_inPayload, w_skidData, w_outData, w_outNext;
    logic [WB_W-1:0]  w_outWb;
    logic [1:0]       w_outM, w_memCtrl;
    logic             r_mConflict;
    logic [CNT_W-1:0] r_stallCnt;

    assign in_ready    = ~w_skidValid;
    assign w_accept    = in_valid & in_ready & ~flush;
    assign w_consume   = w_outValid & out_ready;
    assign w_inPayload = {wb, m, alu_in, store_in, rd_in};

    // The skid entry is always older than any new input, so it refills the output slot first.
    assign w_outLoad   = ~flush & ((w_skidValid & w_consume) |
                                   (w_accept & (~w_outValid | w_consume)));
    assign w_outClear  = flush | (w_consume & ~w_outLoad);
    assign w_outNext   = w_skidValid ? w_skidData : w_inPayload;
    assign w_skidLoad  = w_accept & w_outValid & ~w_consume;
    assign w_skidClear = flush | (w_skidValid & w_consume);

    pipe_slot #(.W(PAY_W)) u_outSlot (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_outLoad),
        .i_clear (w_outClear),
        .i_data  (w_outNext),
        .o_valid (w_outValid),
        .o_data  (w_outData)
    );

    pipe_slot #(.W(PAY_W)) u_skidSlot (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skidLoad),
        .i_clear (w_skidClear),
        .i_data  (w_inPayload),
        .o_valid (w_skidValid),
        .o_data  (w_skidData)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mConflict <= 1'b0;
            r_stallCnt  <= '0;
        end else begin
            if (w_accept && m == 2'b11) begin
                r_mConflict <= 1'b1;
            end
            if (w_outValid && !out_ready && r_stallCnt != '1) begin
                r_stallCnt <= r_stallCnt + CNT_ONE;
            end
        end
    end

    assign {w_outWb, w_outM, alu_out, store_out, rd_out} = w_outData;
    assign w_memCtrl  = mem_ctrl(w_outM, w_outValid);
    assign mem_read   = w_memCtrl[1];
    assign mem_write  = w_memCtrl[0];
    assign wb_out     = w_outValid ? w_outWb : '0;
    assign out_valid  = w_outValid;
    assign m_conflict = r_mConflict;
    assign stall_cnt  = r_stallCnt;

endmodule
